imem_boot_loader: RTL

Upstream boot stage for the single-cycle MIPS core (`main`). It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into instruction memory through a dedicated write port and holds the core in reset until a complete, checksum-verified program image has been loaded. After a good load it releases the core; a bad image leaves the core parked in reset and flags an error.

---
 rtl/imem_boot_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image, writes it
// into instruction memory word by word and releases the core only on a good load.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              load_done_o,
  output logic              load_error_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_RUN    = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  typedef logic [ADDR_W:0] cnt_t;
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  cnt_t              idx_q, idx_d;
  cnt_t              len_q, len_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [7:0]        csum_q, csum_d;

  // Handshake: a byte moves on a rising edge with in_valid_i & in_ready_o high;
  // a coincident start_i wins and the byte is dropped.
  logic        xfer;
  logic [16:0] n_full;
  logic        last_word;

  assign xfer      = in_valid_i & ready_q & ~start_i;
  assign n_full    = {1'b0, in_data_i, len_lo_q};
  assign last_word = (idx_q + cnt_t'(1)) == len_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_LEN_LO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_LEN_LO;
    end else if (xfer) begin
      case (state_q)
        S_LEN_LO: state_d = S_LEN_HI;
        S_LEN_HI: begin
          if (n_full > CAP)       state_d = S_ERROR;
          else if (n_full == '0)  state_d = S_CSUM;
          else                    state_d = S_DATA;
        end
        S_DATA:   if (byte_cnt_q == 2'd3 && last_word) state_d = S_CSUM;
        S_CSUM:   state_d = (csum_q == in_data_i) ? S_RUN : S_ERROR;
        default:  state_d = state_q;
      endcase
    end
  end

  // Status flags are registered from the next state so they change on the same
  // edge as the state itself.
  always_comb begin
    ready_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                  (state_d == S_DATA)   || (state_d == S_CSUM);
    cpu_reset_d = (state_d != S_RUN);
    done_d      = (state_d == S_RUN);
    err_d       = (state_d == S_ERROR);
  end

  always_comb begin
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    len_lo_d   = len_lo_q;
    csum_d     = csum_q;
    if (start_i) begin
      byte_cnt_d = '0;
      idx_d      = '0;
      csum_d     = '0;
    end else if (xfer) begin
      case (state_q)
        S_LEN_LO: len_lo_d = in_data_i;
        S_LEN_HI: len_d    = n_full[ADDR_W:0];
        S_DATA: begin
          csum_d = csum_q ^ in_data_i;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = idx_q[ADDR_W-1:0];
            wdata_d    = {in_data_i, asm_q};
            idx_d      = idx_q + cnt_t'(1);
            byte_cnt_d = '0;
          end else begin
            // Bytes arrive LSB first, so shifting down leaves byte 0 lowest.
            asm_d      = {in_data_i, asm_q[23:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ready_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      byte_cnt_q  <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      len_lo_q    <= '0;
      csum_q      <= '0;
    end else begin
      ready_q     <= ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      byte_cnt_q  <= byte_cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      len_lo_q    <= len_lo_d;
      csum_q      <= csum_d;
    end
  end

  assign in_ready_o     = ready_q;
  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign cpu_reset_o    = cpu_reset_q;
  assign load_done_o    = done_q;
  assign load_error_o   = err_q;
  assign words_loaded_o = idx_q;
  assign state_o        = state_q;

endmodule
